mmio_sim_console: RTL

Memory-mapped responder on the CPU data-memory bus that gives simulated programs a way to print and to end the run. Stores to its address window push characters into a transmit FIFO or write a `tohost` pass/fail code; loads return status and a free-running cycle count. It sits beside `data_mem` in the CPU top, where the top muxes `read_data` using `sel`. The testbench watches `tx_valid`/`tx_byte`, and calls `$finish` on `done` instead of using a fixed timeout.

---
 rtl/mmio_sim_console.sv | 114 +++++++++++
 1 files changed

// File: rtl/mmio_sim_console.sv
// Simulation console on the CPU data bus: stores print bytes through a TX FIFO or
// post a tohost pass/fail code; loads return the code, status and a cycle counter.
module mmio_sim_console #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        write_en,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        sel,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    input  logic        tx_ready,
    output logic        halt,
    output logic        pass,
    output logic        done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;
    logic           overflow;
    logic [31:0]    code;
    logic [31:0]    cycle;
    logic [1:0]     off;
    logic           full, empty, pop, push_req, push_ok, code_ok;
    logic [31:0]    status;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];
    assign off      = addr[3:2];
    assign sel      = (addr[31:4] == BASE_ADDR[31:4]);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);

    // tx stream: a byte transfers on any rising edge where tx_valid && tx_ready;
    // tx_valid never depends on tx_ready and the head byte holds until taken.
    assign tx_valid = !empty;
    assign tx_byte  = empty ? 8'h00 : mem[rd_ptr];
    assign pop      = tx_valid & tx_ready;
    assign push_req = write_en & sel & (off == 2'd1);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push_ok  = push_req & (!full | pop);
    assign code_ok  = write_en & sel & (off == 2'd0) & !halt & (write_data != 32'd0);

    assign done     = (state == S_DONE);
    assign status   = {overflow, done, halt, pass, full, empty, 10'b0, 16'(count)};

    always_comb begin
        read_data = 32'd0;
        if (sel) begin
            case (off)
                2'd0:    read_data = code;
                2'd2:    read_data = status;
                2'd3:    read_data = cycle;
                default: read_data = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RUN:   if (code_ok) state_next = S_DRAIN;
            // Registered count: an emptying pop is seen one cycle later.
            S_DRAIN: if (count == '0 && !push_ok) state_next = S_DONE;
            S_DONE:  state_next = S_DONE;
            default: state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= write_data[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_RUN;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            code     <= 32'd0;
            halt     <= 1'b0;
            pass     <= 1'b0;
            cycle    <= 32'd0;
        end else begin
            state <= state_next;
            cycle <= cycle + 32'd1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            if (push_req && !push_ok) overflow <= 1'b1;
            if (code_ok) begin
                code <= write_data;
                halt <= 1'b1;
                pass <= (write_data == 32'd1);
            end
        end
    end
endmodule
